data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words stored (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, number of wait-state cycles inserted before each response (0..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  1  CPU request present.
REQ-006 SHALL have port req_ready_o  output  1  responder able to accept a request.
REQ-007 SHALL have port req_we_i  input  1  1 = store word, 0 = load word.
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data.
REQ-010 SHALL have port rsp_valid_o  output  1  response present.
REQ-011 SHALL have port rsp_ready_i  input  1  CPU able to take the response.
REQ-012 SHALL have port rsp_rdata_o  output  32  load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err_o  output  1  request was rejected (see Configuration).

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-015 SHALL accept a request on an edge where state = IDLE and req_valid_i = 1, latching we, addr, wdata.
REQ-016 SHALL, on accept, go to WAIT loaded with WAIT_CYCLES if WAIT_CYCLES > 0, else go directly to RESP.
REQ-017 SHALL decrement the wait counter each WAIT cycle and enter RESP on the edge where the counter equals 1.
REQ-018 SHALL perform the store and register the load data on the edge entering RESP; rsp_valid_o rises WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 SHALL index memory with addr[log2(DEPTH_WORDS)+1:2].
REQ-020 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable in RESP until rsp_ready_i = 1, then return to IDLE on that edge.
REQ-021 SHALL ignore req_* inputs while not in IDLE (no queuing); a new request is accepted no earlier than the cycle after the response handshake.
REQ-022 SHALL make a store visible to the next accepted load at the same address (no stale data).
REQ-023 SHALL drive rsp_rdata_o = 0 and rsp_err_o = 0 outside RESP.

Reset
REQ-024 SHALL on rst_i = 1 force state IDLE, wait counter 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, req_ready_o 1 on the next cycle.
REQ-025 SHALL give rst_i priority over an accept or handshake on the same edge.
REQ-026 SHALL drop a request in progress on reset; a store not yet reaching the RESP-entry edge SHALL not modify memory.
REQ-027 SHALL NOT clear memory contents on reset; memory initialises to all-zero at time zero.

Configuration
REQ-028 SHALL, with macro DATA_MEM_ERR_CHECK_EN defined, flag rsp_err_o = 1 for addr[1:0] != 0 or addr >= 4*DEPTH_WORDS, suppress the store and return rdata 0, with unchanged latency.
REQ-029 SHALL, without DATA_MEM_ERR_CHECK_EN, ignore addr[1:0] and upper out-of-range bits (address wraps modulo DEPTH_WORDS) and tie rsp_err_o to 0.

Verification
REQ-030 SHALL cover: store 0xDEADBEEF @0x10, then load @0x10, rsp_ready_i=1 -> load rdata 0xDEADBEEF, err 0, rsp_valid_o 3 cycles after each accept (WAIT_CYCLES=2).
REQ-031 SHALL cover: load accepted, rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rdata stable all 5 cycles, req_ready_o 0 throughout, IDLE one edge after rsp_ready_i=1.
REQ-032 SHALL cover: rst_i pulsed one cycle after accepting store 0x12345678 @0x20, then load @0x20 -> rdata 0x00000000 (store dropped), outputs zero during reset.
REQ-033 SHALL cover: with DATA_MEM_ERR_CHECK_EN, store @0x102 and load @0x100 (DEPTH_WORDS=64) -> both err 1, rdata 0, memory unchanged; without macro, store 0xA5 @0x102 then load @0x100 -> rdata 0xA5 (0x100 wraps to word 0, so also visible @0x000).
REQ-034 SHALL cover: WAIT_CYCLES=0, back-to-back loads with req_valid_i held 1 and rsp_ready_i held 1 -> rsp_valid_o one cycle after each accept, accepts every second cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake with fixed wait states.
// Optional address checking is enabled by defining DATA_MEM_ERR_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            ready_d, valid_d, err_d;
  logic [31:0]     rdata_d;
  logic            enter_resp;
  logic            mem_we;
  logic            cur_we;
  logic [31:0]     cur_addr, cur_wdata;
  logic [AW-1:0]   idx;
  logic            addr_err;
  logic            unused_addr;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  // With zero wait states the access happens on the accepting edge, so use the live request there.
  assign cur_we    = (state_q == IDLE) ? req_we_i    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
  assign idx       = cur_addr[AW+1:2];
  assign unused_addr = ^{cur_addr[31:AW+2], cur_addr[1:0]};

`ifdef DATA_MEM_ERR_CHECK_EN
  assign addr_err = (cur_addr[1:0] != 2'b00) || (cur_addr >= 32'(4 * DEPTH_WORDS));
`else
  assign addr_err = 1'b0;
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    valid_d    = rsp_valid_o;
    rdata_d    = rsp_rdata_o;
    err_d      = rsp_err_o;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES);
          end else begin
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) enter_resp = 1'b1;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      state_d = RESP;
      cnt_d   = '0;
      valid_d = 1'b1;
      err_d   = addr_err;
      rdata_d = (addr_err || cur_we) ? 32'h0 : mem[idx];
    end

    ready_d = (state_d == IDLE);
    mem_we  = enter_resp && cur_we && !addr_err && !rst_i;
  end

  // State and output registers; reset wins over any accept or handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_o <= ready_d;
      rsp_valid_o <= valid_d;
      rsp_rdata_o <= rdata_d;
      rsp_err_o   <= err_d;
    end
  end

  // Storage array; never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx] <= cur_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: transaction-level model compared every cycle, plus literal checks.
// Instance a uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int WA = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_rv, a_we, a_rr, a_rdy, a_vld, a_err;
  logic [31:0] a_addr, a_wdata, a_rd;
  logic b_rst, b_rv, b_we, b_rr, b_rdy, b_vld, b_err;
  logic [31:0] b_addr, b_wdata, b_rd;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .req_valid_i(a_rv), .req_ready_o(a_rdy), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .rsp_valid_o(a_vld), .rsp_ready_i(a_rr),
    .rsp_rdata_o(a_rd), .rsp_err_o(a_err));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .req_valid_i(b_rv), .req_ready_o(b_rdy), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata), .rsp_valid_o(b_vld), .rsp_ready_i(b_rr),
    .rsp_rdata_o(b_rd), .rsp_err_o(b_err));

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  typedef struct {
    bit          busy;
    int          age;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } mdl_t;

  mdl_t        m  [2];
  logic [31:0] mm [2][DEPTH];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance model k by one clock edge: a transaction occupies age 1..w, then responds until taken.
  task automatic mstep(input int k, input int w, input logic rst, input logic rv, input logic we,
                       input logic [31:0] a, input logic [31:0] wd, input logic rr);
    bit adv;
    bit e;
    int unsigned ix;
    adv = 1'b0;
    if (rst) begin
      m[k].busy = 1'b0;
      m[k].age  = 0;
      return;
    end
    if (m[k].busy) begin
      if (m[k].age >= w + 1) begin
        if (rr) m[k].busy = 1'b0;
      end else adv = 1'b1;
    end else if (rv) begin
      m[k].busy  = 1'b1;
      m[k].age   = 0;
      m[k].we    = we;
      m[k].addr  = a;
      m[k].wdata = wd;
      adv = 1'b1;
    end
    if (adv) begin
      m[k].age++;
      if (m[k].age == w + 1) begin
`ifdef DATA_MEM_ERR_CHECK_EN
        e = (m[k].addr[1:0] != 2'b00) || (m[k].addr >= 4 * DEPTH);
`else
        e = 1'b0;
`endif
        ix = (m[k].addr / 4) % DEPTH;
        m[k].err = e;
        if (e) m[k].rdata = 32'h0;
        else if (m[k].we) begin
          mm[k][ix] = m[k].wdata;
          m[k].rdata = 32'h0;
        end else m[k].rdata = mm[k][ix];
      end
    end
  endtask

  task automatic chk(input int k, input int w, input logic rdy, input logic vld,
                     input logic [31:0] rd, input logic er);
    bit v;
    v = m[k].busy && (m[k].age >= w + 1);
    cmp($sformatf("mdl%0d_ready", k), rdy, !m[k].busy);
    cmp($sformatf("mdl%0d_valid", k), vld, v);
    cmp($sformatf("mdl%0d_rdata", k), rd, v ? m[k].rdata : 32'h0);
    cmp($sformatf("mdl%0d_err", k), er, v ? m[k].err : 1'b0);
  endtask

  always @(posedge clk) begin
    if (a_rst) started = 1'b1;
    mstep(0, WA, a_rst, a_rv, a_we, a_addr, a_wdata, a_rr);
    mstep(1, 0, b_rst, b_rv, b_we, b_addr, b_wdata, b_rr);
  end

  always @(negedge clk) begin
    if (started) begin
      chk(0, WA, a_rdy, a_vld, a_rd, a_err);
      chk(1, 0, b_rdy, b_vld, b_rd, b_err);
    end
  end

  // Issue one request on instance a (called at a negedge while idle, rsp ready held 1).
  task automatic do_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er);
    a_rv = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      a_rv = 1'b0;
    end while (!a_vld && lat < 20);
    rd = a_rd;
    er = a_err;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rd;
    logic er;
    logic [7:0] pat;

    for (int k = 0; k < 2; k++) begin
      m[k] = '{busy: 1'b0, age: 0, we: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, err: 1'b0};
      for (int i = 0; i < int'(DEPTH); i++) mm[k][i] = 32'h0;
    end
    a_rst = 1; a_rv = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_rr = 1;
    b_rst = 1; b_rv = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_rr = 1;
    repeat (3) @(negedge clk);
    cmp("rst_ready", a_rdy, 1'b1);
    cmp("rst_valid", a_vld, 1'b0);
    cmp("rst_rdata", a_rd, 32'h0);
    cmp("rst_err", a_err, 1'b0);
    a_rst = 0; b_rst = 0;

    // store then load at 0x10
    do_a(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    cmp("st10_lat", 32'(lat), 32'd3);
    cmp("st10_rdata", rd, 32'h0);
    cmp("st10_err", er, 1'b0);
    do_a(1'b0, 32'h10, 32'h0, lat, rd, er);
    cmp("ld10_lat", 32'(lat), 32'd3);
    cmp("ld10_rdata", rd, 32'hDEADBEEF);
    cmp("ld10_err", er, 1'b0);

    // response back-pressure
    a_rr = 0; a_rv = 1; a_we = 0; a_addr = 32'h10;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      a_rv = 0;
    end while (!a_vld && lat < 20);
    cmp("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      cmp("bp_valid", a_vld, 1'b1);
      cmp("bp_rdata", a_rd, 32'hDEADBEEF);
      cmp("bp_ready", a_rdy, 1'b0);
      @(negedge clk);
    end
    a_rr = 1;
    cmp("bp_valid_last", a_vld, 1'b1);
    @(negedge clk);
    cmp("bp_idle_ready", a_rdy, 1'b1);
    cmp("bp_idle_valid", a_vld, 1'b0);

    // reset during a store in flight drops it
    a_rv = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h12345678;
    @(negedge clk);
    a_rv = 0; a_rst = 1;
    @(negedge clk);
    cmp("rstmid_ready", a_rdy, 1'b1);
    cmp("rstmid_valid", a_vld, 1'b0);
    cmp("rstmid_rdata", a_rd, 32'h0);
    cmp("rstmid_err", a_err, 1'b0);
    a_rst = 0;
    do_a(1'b0, 32'h20, 32'h0, lat, rd, er);
    cmp("ld20_rdata", rd, 32'h0);
    cmp("ld20_lat", 32'(lat), 32'd3);

    // misaligned / out-of-range addresses
    do_a(1'b1, 32'h102, 32'h000000A5, lat, rd, er);
`ifdef DATA_MEM_ERR_CHECK_EN
    cmp("st102_err", er, 1'b1);
    cmp("st102_lat", 32'(lat), 32'd3);
    do_a(1'b0, 32'h100, 32'h0, lat, rd, er);
    cmp("ld100_err", er, 1'b1);
    cmp("ld100_rdata", rd, 32'h0);
    do_a(1'b0, 32'h0, 32'h0, lat, rd, er);
    cmp("ld000_rdata", rd, 32'h0);
`else
    cmp("st102_err", er, 1'b0);
    cmp("st102_lat", 32'(lat), 32'd3);
    do_a(1'b0, 32'h100, 32'h0, lat, rd, er);
    cmp("ld100_err", er, 1'b0);
    cmp("ld100_rdata", rd, 32'h000000A5);
    do_a(1'b0, 32'h0, 32'h0, lat, rd, er);
    cmp("ld000_rdata", rd, 32'h000000A5);
`endif

    // last word in range
    do_a(1'b1, 32'hFC, 32'hCAFEF00D, lat, rd, er);
    do_a(1'b0, 32'hFC, 32'h0, lat, rd, er);
    cmp("ldFC_rdata", rd, 32'hCAFEF00D);
    cmp("ldFC_err", er, 1'b0);

    // zero wait states, requests and response-ready held high
    b_rv = 1; b_we = 1; b_addr = 32'h4; b_wdata = 32'h77;
    pat = 8'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[7-i] = b_vld;
      if (i == 0) b_we = 0;
      if (i == 2) cmp("b2b_rdata", b_rd, 32'h77);
    end
    b_rv = 0;
    cmp("b2b_pattern", {24'h0, pat}, 32'h000000AA);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
